// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter owner and instruction-memory sequencer.
// Keeps at most one memory request outstanding and buffers responses in a
// 2-entry queue that feeds decode. Branch redirects flush the queue and
// discard any in-flight response.
// Optional feature: define FETCH_CTRL_PERF_EN to build the wait-cycle and
// redirect counters; otherwise the perf outputs are tied to zero.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc_F,
    input  logic [63:0] PCBranch_F,
    input  logic        stall_D,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [63:0] imem_addr_F,
    output logic        valid_F,
    output logic [31:0] instr_F,
    output logic [63:0] pc_F,
    output logic [31:0] perf_wait_cycles,
    output logic [31:0] perf_redirects
);

    typedef enum logic [1:0] {
        BOOT,
        IDLE,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic [63:0] req_addr;
    logic [63:0] req_addr_next;
    logic        drop_pend;
    logic        drop_next;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [1:0]  count_upd;

    logic [63:0] fifo_addr  [2];
    logic [31:0] fifo_instr [2];

    logic        in_wait;
    logic        pop;
    logic        push;
    logic        issue_ok;
    logic        issue;
    logic        wr_sel;

    // Queue bookkeeping: handshake terms and the post-edge occupancy.
    always_comb begin
        in_wait    = (state == WAIT);
        pop        = (count != 2'd0) && !stall_D;
        push       = imem_ready && in_wait && !drop_pend && !PCSrc_F;
        count_next = count + {1'b0, push} - {1'b0, pop};
        // A new request is only allowed if its response is guaranteed a slot.
        issue_ok   = (count_next <= 2'd1);
        count_upd  = PCSrc_F ? 2'd0 : count_next;
        // Write slot is count - pop; for the reachable cases that is count[0] ^ pop.
        wr_sel     = count[0] ^ pop;
    end

    // Next-state, next-PC and request-address selection; redirect wins.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        drop_next     = drop_pend;
        issue         = 1'b0;

        if (PCSrc_F) begin
            pc_next = PCBranch_F;
            if (in_wait && !imem_ready) begin
                // Response still in flight: remember to throw it away.
                drop_next  = 1'b1;
                state_next = WAIT;
            end else begin
                drop_next  = 1'b0;
                state_next = IDLE;
            end
        end else begin
            unique case (state)
                BOOT: issue = 1'b1;
                IDLE: issue = issue_ok;
                WAIT: begin
                    if (imem_ready) begin
                        drop_next = 1'b0;
                        if (issue_ok) begin
                            issue = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = BOOT;
            endcase

            if (issue) begin
                req_addr_next = pc;
                pc_next       = pc + 64'd4;
                state_next    = WAIT;
            end
        end
    end

    // Control registers: state, PC, request address, occupancy, drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            req_addr  <= '0;
            count     <= '0;
            drop_pend <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            req_addr  <= req_addr_next;
            count     <= count_upd;
            drop_pend <= drop_next;
        end
    end

    // Queue storage: shift on pop, write the response behind the live entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_addr[0]  <= '0;
            fifo_addr[1]  <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else if (!PCSrc_F) begin
            if (pop) begin
                fifo_addr[0]  <= fifo_addr[1];
                fifo_instr[0] <= fifo_instr[1];
            end
            // Later assignment wins when pop and push target slot 0 together.
            if (push) begin
                fifo_addr[wr_sel]  <= req_addr;
                fifo_instr[wr_sel] <= imem_rdata;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        imem_req    = in_wait;
        imem_addr_F = req_addr;
        valid_F     = (count != 2'd0);
        instr_F     = valid_F ? fifo_instr[0] : '0;
        pc_F        = valid_F ? fifo_addr[0] : '0;
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] wait_cnt;
    logic [31:0] redir_cnt;

    // Performance counters: stalled-on-memory cycles and redirects seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            redir_cnt <= '0;
        end else begin
            if (in_wait && !imem_ready) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (PCSrc_F) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
        end
    end

    assign perf_wait_cycles = wait_cnt;
    assign perf_redirects   = redir_cnt;
`else
    assign perf_wait_cycles = '0;
    assign perf_redirects   = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed vector table, a mid-request reset
// sequence, then randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [63:0] RPC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        stall_D;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [63:0] imem_addr_F;
    logic        valid_F;
    logic [31:0] instr_F;
    logic [63:0] pc_F;
    logic [31:0] perf_wait_cycles;
    logic [31:0] perf_redirects;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk              (clk),
        .reset            (reset),
        .PCSrc_F          (PCSrc_F),
        .PCBranch_F       (PCBranch_F),
        .stall_D          (stall_D),
        .imem_ready       (imem_ready),
        .imem_rdata       (imem_rdata),
        .imem_req         (imem_req),
        .imem_addr_F      (imem_addr_F),
        .valid_F          (valid_F),
        .instr_F          (instr_F),
        .pc_F             (pc_F),
        .perf_wait_cycles (perf_wait_cycles),
        .perf_redirects   (perf_redirects)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs for one edge and outputs expected after it.
    typedef struct {
        logic        stall;
        logic        ready;
        logic        br;
        logic [63:0] tgt;
        logic [31:0] rdata;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    // Reference model: one outstanding flag, a queue of returned entries.
    typedef struct {
        logic [63:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_out;
    bit          m_drop;
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    logic [31:0] m_wait;
    logic [31:0] m_redir;

    task automatic model_reset();
        mq.delete();
        m_out   = 1'b0;
        m_drop  = 1'b0;
        m_pc    = RPC;
        m_addr  = '0;
        m_wait  = '0;
        m_redir = '0;
    endtask

    task automatic model_step(input bit st, input bit rd, input bit br,
                              input logic [63:0] tg, input logic [31:0] dat);
        bit   pop;
        bit   done;
        ent_t e;
`ifdef FETCH_CTRL_PERF_EN
        if (m_out && !rd) m_wait = m_wait + 32'd1;
        if (br) m_redir = m_redir + 32'd1;
`endif
        if (br) begin
            m_pc = tg;
            mq.delete();
            if (m_out && !rd) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
        end else begin
            pop  = (mq.size() != 0) && !st;
            done = m_out && rd;
            if (pop) void'(mq.pop_front());
            if (done) begin
                if (!m_drop) begin
                    e.a = m_addr;
                    e.d = dat;
                    mq.push_back(e);
                end
                m_drop = 1'b0;
            end
            if (!m_out || done) begin
                if (mq.size() <= 1) begin
                    m_addr = m_pc;
                    m_pc   = m_pc + 64'd4;
                    m_out  = 1'b1;
                end else begin
                    m_out = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [63:0] exp_pc;
        logic [31:0] exp_ins;
        bit          r_st;
        bit          r_rd;
        bit          r_br;
        logic [63:0] r_tg;
        logic [31:0] r_dat;

        // stall ready br target rdata | req addr valid pc instr
        tv[0]  = '{1'b0, 1'b1, 1'b0, 64'h0, 32'h0,          1'b1, 64'h100, 1'b0, 64'h0,   32'h0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_0000,  1'b1, 64'h104, 1'b1, 64'h100, 32'hA000_0000};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_0001,  1'b1, 64'h108, 1'b1, 64'h104, 32'hA000_0001};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'h108, 1'b0, 64'h0,   32'h0};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'h108, 1'b0, 64'h0,   32'h0};
        tv[5]  = '{1'b1, 1'b1, 1'b0, 64'h0, 32'hA000_0002,  1'b1, 64'h10C, 1'b1, 64'h108, 32'hA000_0002};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 64'h0, 32'hA000_0003,  1'b0, 64'h10C, 1'b1, 64'h108, 32'hA000_0002};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 64'h0, 32'h0,          1'b0, 64'h10C, 1'b1, 64'h108, 32'hA000_0002};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'h110, 1'b1, 64'h10C, 32'hA000_0003};
        tv[9]  = '{1'b1, 1'b1, 1'b0, 64'h0, 32'hA000_0004,  1'b0, 64'h110, 1'b1, 64'h10C, 32'hA000_0003};
        tv[10] = '{1'b1, 1'b1, 1'b1, 64'h2000, 32'h0,       1'b0, 64'h110, 1'b0, 64'h0,   32'h0};
        tv[11] = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'h2000, 1'b0, 64'h0,  32'h0};
        tv[12] = '{1'b0, 1'b0, 1'b1, 64'h3000, 32'h0,       1'b1, 64'h2000, 1'b0, 64'h0,  32'h0};
        tv[13] = '{1'b0, 1'b0, 1'b1, 64'h4000, 32'h0,       1'b1, 64'h2000, 1'b0, 64'h0,  32'h0};
        tv[14] = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hDEAD_BEEF,  1'b1, 64'h4000, 1'b0, 64'h0,  32'h0};
        tv[15] = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_0005,  1'b1, 64'h4004, 1'b1, 64'h4000, 32'hA000_0005};
        tv[16] = '{1'b0, 1'b1, 1'b1, 64'h5000, 32'hA000_0006, 1'b0, 64'h4004, 1'b0, 64'h0, 32'h0};
        tv[17] = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'h5000, 1'b0, 64'h0,  32'h0};
        tv[18] = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_0007,  1'b1, 64'h5004, 1'b1, 64'h5000, 32'hA000_0007};
        tv[19] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hA000_0008,
                   1'b0, 64'h5004, 1'b0, 64'h0, 32'h0};
        tv[20] = '{1'b0, 1'b0, 1'b0, 64'h0, 32'h0,          1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 32'h0};
        tv[21] = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_0009,  1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hA000_0009};
        tv[22] = '{1'b0, 1'b1, 1'b0, 64'h0, 32'hA000_000A,  1'b1, 64'h4, 1'b1, 64'h0, 32'hA000_000A};

        reset      = 1'b1;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        stall_D    = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {63'b0, imem_req}, 64'h0);
        chk("rst_addr",  imem_addr_F, 64'h0);
        chk("rst_valid", {63'b0, valid_F}, 64'h0);
        chk("rst_pc",    pc_F, 64'h0);
        chk("rst_instr", {32'b0, instr_F}, 64'h0);
        chk("rst_pwait", {32'b0, perf_wait_cycles}, 64'h0);
        chk("rst_predir", {32'b0, perf_redirects}, 64'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall_D    = tv[i].stall;
            imem_ready = tv[i].ready;
            PCSrc_F    = tv[i].br;
            PCBranch_F = tv[i].tgt;
            imem_rdata = tv[i].rdata;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_req", i),   {63'b0, imem_req}, {63'b0, tv[i].e_req});
            chk($sformatf("vec%0d_addr", i),  imem_addr_F, tv[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {63'b0, valid_F}, {63'b0, tv[i].e_valid});
            chk($sformatf("vec%0d_pc", i),    pc_F, tv[i].e_pc);
            chk($sformatf("vec%0d_instr", i), {32'b0, instr_F}, {32'b0, tv[i].e_instr});
        end

        // Asynchronous reset while a request is outstanding.
        stall_D    = 1'b0;
        imem_ready = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        imem_rdata = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req",   {63'b0, imem_req}, 64'h0);
        chk("arst_valid", {63'b0, valid_F}, 64'h0);
        chk("arst_addr",  imem_addr_F, 64'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_req",  {63'b0, imem_req}, 64'h1);
        chk("restart_addr", imem_addr_F, RPC);

        // Randomized traffic against the reference model.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 2) != 0);
            r_br  = ($urandom_range(0, 15) == 0);
            r_tg  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4
                                               : {32'h0, $urandom} & 64'hFFFF_FFFC;
            r_dat = $urandom;
            stall_D    = r_st;
            imem_ready = r_rd;
            PCSrc_F    = r_br;
            PCBranch_F = r_tg;
            imem_rdata = r_dat;
            @(posedge clk);
            model_step(r_st, r_rd, r_br, r_tg, r_dat);
            #1;
            exp_pc  = (mq.size() != 0) ? mq[0].a : 64'h0;
            exp_ins = (mq.size() != 0) ? mq[0].d : 32'h0;
            chk("rnd_req",   {63'b0, imem_req}, {63'b0, m_out});
            chk("rnd_addr",  imem_addr_F, m_addr);
            chk("rnd_valid", {63'b0, valid_F}, {63'b0, (mq.size() != 0)});
            chk("rnd_pc",    pc_F, exp_pc);
            chk("rnd_instr", {32'b0, instr_F}, {32'b0, exp_ins});
            chk("rnd_pwait", {32'b0, perf_wait_cycles}, {32'b0, m_wait});
            chk("rnd_predir", {32'b0, perf_redirects}, {32'b0, m_redir});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
